button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_button_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions a raw active-low pushbutton into clean, registered events:
// a two-flop synchronizer feeds a five-state debounce / auto-repeat FSM that
// shares one counter for press debounce, release debounce and repeat timing.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples to accept a
//                     press or a release (>= 2)
//   REPEAT_DELAY    : cycles from the initial press_pulse to the first
//                     auto-repeat pulse (>= 2)
//   REPEAT_PERIOD   : cycles between successive auto-repeat pulses (>= 2)
//   REPEAT_EN       : 0 disables auto-repeat
//
// Ports
//   clk           : system clock, rising edge
//   reset_sw      : asynchronous active-low reset
//   btn_n         : raw asynchronous pushbutton, low while pressed
//   pressed       : debounced level, high while the press is accepted
//   press_pulse   : one-cycle strobe per accepted press and per auto-repeat
//   release_pulse : one-cycle strobe per accepted release
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset_sw,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W   = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

    // The edge that enters a debounce state already counts as the first
    // stable sample, so debounce terminates when the counter reaches N-2.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sync1_reg, sync2_reg;
    logic             sync;
    logic             pressed_reg, pressed_next;
    logic             press_pulse_reg, press_pulse_next;
    logic             release_pulse_reg, release_pulse_next;

    // Synchronizer flops reset to the released level so a button already
    // held at reset exit is seen as a fresh press.
    always_ff @(posedge clk or negedge reset_sw) begin
        if (!reset_sw) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
        end
    end

    assign sync = ~sync2_reg;

    always_ff @(posedge clk or negedge reset_sw) begin
        if (!reset_sw) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            pressed_reg       <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            pressed_reg       <= pressed_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
        end
    end

    // Counter only increments while below its terminal value and is cleared
    // on every transition, so it can never wrap.
    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sync) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (!sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next       = HELD;
                    cnt_next         = '0;
                    press_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_reg == RD_LAST) begin
                        state_next       = REPEAT;
                        cnt_next         = '0;
                        press_pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!sync) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt_reg == RP_LAST) begin
                    cnt_next         = '0;
                    press_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DB_RELEASE: begin
                // A bounce back to pressed resumes HELD with fresh repeat timing.
                if (sync) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next         = IDLE;
                    cnt_next           = '0;
                    release_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        pressed_next = (state_next == HELD) || (state_next == REPEAT) ||
                       (state_next == DB_RELEASE);
    end

    assign pressed       = pressed_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives two instances (auto-repeat disabled / enabled) from the same button
// and reset with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Edge k is the k-th rising edge after a stimulus segment begins; outputs are
// sampled 1 time unit after that edge, i.e. in the cycle following edge k.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset_sw = 1'b0;
    logic btn_n = 1'b1;

    logic pr0, pp0, rp0;
    logic pr1, pp1, rp1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(0)
    ) dut0 (
        .clk(clk), .reset_sw(reset_sw), .btn_n(btn_n),
        .pressed(pr0), .press_pulse(pp0), .release_pulse(rp0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1)
    ) dut1 (
        .clk(clk), .reset_sw(reset_sw), .btn_n(btn_n),
        .pressed(pr1), .press_pulse(pp1), .release_pulse(rp1)
    );

    typedef struct {
        logic btn;
        logic pr;
        logic pp;
        logic rp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    // Apply btn for the next rising edge, then settle just past it.
    task automatic step(input string tag, input int k, input logic b);
        btn_n = b;
        @(posedge clk);
        #1;
        $display("%s k=%0d btn_n=%b | r0: pr=%b pp=%b rp=%b | r1: pr=%b pp=%b rp=%b",
                 tag, k, b, pr0, pp0, rp0, pr1, pp1, rp1);
    endtask

    function automatic logic in_repeat_set(input int k);
        return (k == 6) || (k == 16) || (k == 19) || (k == 22) || (k == 25) || (k == 28);
    endfunction

    initial begin
        // Clean press then release: low edges 1..8, high from edge 9.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state, checked while reset is held.
        #3;
        chk("rst_pressed0", 0, pr0, 1'b0);
        chk("rst_pulse0",   0, pp0, 1'b0);
        chk("rst_release0", 0, rp0, 1'b0);
        chk("rst_pressed1", 0, pr1, 1'b0);
        chk("rst_pulse1",   0, pp1, 1'b0);
        chk("rst_release1", 0, rp1, 1'b0);
        @(posedge clk);
        #3;
        reset_sw = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) begin
            step("idle", k, 1'b1);
            chk("idle_pressed1", k, pr1, 1'b0);
            chk("idle_pulse1",   k, pp1, 1'b0);
        end

        // Table: clean press and clean release on both instances.
        for (int i = 0; i < 20; i++) begin
            step("vec", i + 1, vecs[i].btn);
            chk("vec_pressed0", i + 1, pr0, vecs[i].pr);
            chk("vec_pulse0",   i + 1, pp0, vecs[i].pp);
            chk("vec_release0", i + 1, rp0, vecs[i].rp);
            chk("vec_pressed1", i + 1, pr1, vecs[i].pr);
            chk("vec_pulse1",   i + 1, pp1, vecs[i].pp);
            chk("vec_release1", i + 1, rp1, vecs[i].rp);
        end

        // Bounce: low 3 edges, high 1, then low; press accepted after edge 10.
        for (int k = 1; k <= 14; k++) begin
            step("bounce", k, (k == 4) ? 1'b1 : 1'b0);
            chk("bounce_pulse1",   k, pp1, (k == 10));
            chk("bounce_pressed1", k, pr1, (k >= 10));
            chk("bounce_release1", k, rp1, 1'b0);
        end

        // Release glitch from HELD: high 2, low 1, then high; release after j=9.
        for (int j = 1; j <= 12; j++) begin
            step("relglitch", j, (j == 3) ? 1'b0 : 1'b1);
            chk("relg_release1", j, rp1, (j == 9));
            chk("relg_pressed1", j, pr1, (j < 9));
            chk("relg_pulse1",   j, pp1, 1'b0);
        end

        // Auto-repeat: held low for edges 1..30.
        for (int k = 1; k <= 30; k++) begin
            step("repeat", k, 1'b0);
            chk("rep_pulse1", k, pp1, in_repeat_set(k));
            chk("rep_pulse0", k, pp0, (k == 6));
            chk("rep_pressed0", k, pr0, (k >= 6));
        end

        // Asynchronous reset between edges while dut1 is in REPEAT.
        #2;
        reset_sw = 1'b0;
        #1;
        chk("arst_pressed1", 0, pr1, 1'b0);
        chk("arst_pulse1",   0, pp1, 1'b0);
        chk("arst_release1", 0, rp1, 1'b0);
        chk("arst_pressed0", 0, pr0, 1'b0);
        #2;
        reset_sw = 1'b1;
        // Button still low: fresh press with full debounce latency.
        for (int k = 1; k <= 9; k++) begin
            step("postrst", k, 1'b0);
            chk("prst_pulse1",   k, pp1, (k == 6));
            chk("prst_pressed1", k, pr1, (k >= 6));
            chk("prst_release1", k, rp1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
